// File: rtl/vscale_debug_module.sv
`default_nettype none
// ============================================================================
//  Module   : vscale_debug_module
//  Purpose  : Minimal RISC-V debug module (0.13 subset) sitting directly in
//             front of vscale_core's debug port. Serves DMI read/write
//             requests to dmcontrol, dmstatus, abstractcs, command and data0.
//             Drives the core's halt/resume requests and runs abstract GPR
//             accesses through single-cycle read/write strobes.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             dmi_req_*             - DMI request channel (valid/ready)
//             dmi_resp_*            - DMI response channel (valid/ready)
//             core_halted           - core is in debug-halt
//             haltreq, resumereq    - run-control requests to the core
//             register_index,
//             debug_addr            - target register of the abstract command
//             debug_read/_write     - one-cycle GPR access strobes
//             debug_wdata/_rdata    - GPR write data / read data
//  Revision : 1.0 - initial release
// ============================================================================
module vscale_debug_module #(
    parameter int DMI_ADDR_WIDTH = 7,
    parameter int XPR_LEN        = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dmi_req_valid,
    output logic                      dmi_req_ready,
    input  logic [1:0]                dmi_req_op,
    input  logic [DMI_ADDR_WIDTH-1:0] dmi_req_addr,
    input  logic [XPR_LEN-1:0]        dmi_req_data,
    output logic                      dmi_resp_valid,
    input  logic                      dmi_resp_ready,
    output logic [XPR_LEN-1:0]        dmi_resp_data,
    output logic [1:0]                dmi_resp_resp,
    input  logic                      core_halted,
    output logic                      haltreq,
    output logic                      resumereq,
    output logic [12:0]               register_index,
    output logic [4:0]                debug_addr,
    output logic                      debug_read,
    output logic                      debug_write,
    output logic [XPR_LEN-1:0]        debug_wdata,
    input  logic [XPR_LEN-1:0]        debug_rdata
);

    localparam logic [DMI_ADDR_WIDTH-1:0] c_ADDR_DATA0      = 'h04;
    localparam logic [DMI_ADDR_WIDTH-1:0] c_ADDR_DMCONTROL  = 'h10;
    localparam logic [DMI_ADDR_WIDTH-1:0] c_ADDR_DMSTATUS   = 'h11;
    localparam logic [DMI_ADDR_WIDTH-1:0] c_ADDR_ABSTRACTCS = 'h16;
    localparam logic [DMI_ADDR_WIDTH-1:0] c_ADDR_COMMAND    = 'h17;
    localparam logic [1:0]                c_OP_READ         = 2'd1;
    localparam logic [1:0]                c_OP_WRITE        = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e               state_q;
    logic                 dmactive_q;
    logic                 haltreq_q;
    logic                 resumereq_q;
    logic                 resumeack_q;
    logic [XPR_LEN-1:0]   data0_q;
    logic [2:0]           cmderr_q;
    logic [12:0]          regno_q;
    logic                 cmd_write_q;
    logic                 debug_read_q;
    logic                 debug_write_q;
    logic                 resp_valid_q;
    logic [XPR_LEN-1:0]   resp_data_q;

    logic                 w_accept;
    logic                 w_wr;
    logic                 w_busy;
    logic                 w_cmd_bad;
    logic [XPR_LEN-1:0]   w_rd_data;

    // Only one transaction may be outstanding on the DMI.
    assign w_accept  = dmi_req_valid && !resp_valid_q;
    assign w_wr      = w_accept && (dmi_req_op == c_OP_WRITE);
    assign w_busy    = (state_q != ST_IDLE);

    // Unsupported command type, or a transfer that is not a 32-bit access to
    // GPRs 0x1000..0x101F (upper regno bits [15:5] must equal 0x080).
    assign w_cmd_bad = (dmi_req_data[31:24] != 8'h00) ||
                       (dmi_req_data[17] &&
                        ((dmi_req_data[22:20] != 3'd2) || (dmi_req_data[15:5] != 11'h080)));

    always_comb begin
        w_rd_data = '0;
        case (dmi_req_addr)
            c_ADDR_DATA0:      w_rd_data = data0_q;
            c_ADDR_DMCONTROL:  w_rd_data = {haltreq_q, 30'b0, dmactive_q};
            c_ADDR_DMSTATUS:   w_rd_data = {14'b0, {2{resumeack_q}}, 4'b0, {2{!core_halted}},
                                            {2{core_halted}}, 1'b1, 3'b0, 4'd2};
            c_ADDR_ABSTRACTCS: w_rd_data = {19'b0, w_busy, 1'b0, cmderr_q, 4'b0, 4'd1};
            default:           w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            dmactive_q    <= 1'b0;
            haltreq_q     <= 1'b0;
            resumereq_q   <= 1'b0;
            resumeack_q   <= 1'b0;
            data0_q       <= '0;
            cmderr_q      <= 3'd0;
            regno_q       <= 13'd0;
            cmd_write_q   <= 1'b0;
            debug_read_q  <= 1'b0;
            debug_write_q <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
        end else begin
            // Response channel: read data is captured at acceptance.
            if (resp_valid_q && dmi_resp_ready) begin
                resp_valid_q <= 1'b0;
            end
            if (w_accept) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= (dmi_req_op == c_OP_READ) ? w_rd_data : '0;
            end

            // Strobes are single-cycle; they are only raised on command start.
            debug_read_q  <= 1'b0;
            debug_write_q <= 1'b0;

            case (state_q)
                ST_EXEC: state_q <= ST_WAIT;
                ST_WAIT: begin
                    // GPR read data is valid the cycle after the read strobe.
                    if (!cmd_write_q) begin
                        data0_q <= debug_rdata;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            if (resumereq_q && !core_halted) begin
                resumereq_q <= 1'b0;
                resumeack_q <= 1'b1;
            end

            // While dmactive is low the DM is held cleared and ignores accesses.
            if (w_wr && dmactive_q) begin
                case (dmi_req_addr)
                    c_ADDR_DATA0: begin
                        if (w_busy) begin
                            if (cmderr_q == 3'd0) begin
                                cmderr_q <= 3'd1;
                            end
                        end else begin
                            data0_q <= dmi_req_data;
                        end
                    end
                    c_ADDR_ABSTRACTCS: cmderr_q <= cmderr_q & ~dmi_req_data[10:8];
                    c_ADDR_COMMAND: begin
                        if (cmderr_q == 3'd0) begin
                            if (w_busy) begin
                                cmderr_q <= 3'd1;
                            end else if (w_cmd_bad) begin
                                cmderr_q <= 3'd2;
                            end else if (!core_halted) begin
                                cmderr_q <= 3'd4;
                            end else if (dmi_req_data[17]) begin
                                state_q       <= ST_EXEC;
                                regno_q       <= dmi_req_data[12:0];
                                cmd_write_q   <= dmi_req_data[16];
                                debug_write_q <= dmi_req_data[16];
                                debug_read_q  <= !dmi_req_data[16];
                            end
                        end
                    end
                    default: ;
                endcase
            end

            // dmcontrol comes last so that clearing dmactive overrides
            // everything else happening in the same cycle.
            if (w_wr && (dmi_req_addr == c_ADDR_DMCONTROL)) begin
                dmactive_q <= dmi_req_data[0];
                if (!dmi_req_data[0]) begin
                    haltreq_q     <= 1'b0;
                    resumereq_q   <= 1'b0;
                    resumeack_q   <= 1'b0;
                    data0_q       <= '0;
                    cmderr_q      <= 3'd0;
                    state_q       <= ST_IDLE;
                    debug_read_q  <= 1'b0;
                    debug_write_q <= 1'b0;
                end else begin
                    haltreq_q <= dmi_req_data[31];
                    // A simultaneous halt request takes priority over resume.
                    if (dmi_req_data[30] && !dmi_req_data[31]) begin
                        resumereq_q <= 1'b1;
                        resumeack_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign dmi_req_ready  = !resp_valid_q;
    assign dmi_resp_valid = resp_valid_q;
    assign dmi_resp_data  = resp_data_q;
    assign dmi_resp_resp  = 2'b00;
    assign haltreq        = haltreq_q & dmactive_q;
    assign resumereq      = resumereq_q;
    assign register_index = regno_q;
    assign debug_addr     = regno_q[4:0];
    assign debug_read     = debug_read_q;
    assign debug_write    = debug_write_q;
    assign debug_wdata    = debug_write_q ? data0_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_vscale_debug_module.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vscale_debug_module
//  Purpose  : Self-checking bench for vscale_debug_module. A behavioural
//             model predicts DMI responses and GPR strobes; a monitor pops
//             and compares them as the DUT presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vscale_debug_module;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dmi_req_valid = 1'b0;
    logic        dmi_req_ready;
    logic [1:0]  dmi_req_op = 2'd0;
    logic [6:0]  dmi_req_addr = 7'd0;
    logic [31:0] dmi_req_data = 32'd0;
    logic        dmi_resp_valid;
    logic        dmi_resp_ready;
    logic [31:0] dmi_resp_data;
    logic [1:0]  dmi_resp_resp;
    logic        core_halted;
    logic        haltreq;
    logic        resumereq;
    logic [12:0] register_index;
    logic [4:0]  debug_addr;
    logic        debug_read;
    logic        debug_write;
    logic [31:0] debug_wdata;
    logic [31:0] debug_rdata;

    always #5 clk = ~clk;

    vscale_debug_module #(.DMI_ADDR_WIDTH(7), .XPR_LEN(32)) dut (
        .clk(clk), .reset(reset),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_op(dmi_req_op), .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data),
        .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
        .dmi_resp_data(dmi_resp_data), .dmi_resp_resp(dmi_resp_resp),
        .core_halted(core_halted), .haltreq(haltreq), .resumereq(resumereq),
        .register_index(register_index), .debug_addr(debug_addr),
        .debug_read(debug_read), .debug_write(debug_write),
        .debug_wdata(debug_wdata), .debug_rdata(debug_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // ---------------- stimulus controls ----------------
    int          halt_mode  = 0;   // 0: not halted, 1: halted, 2: random toggling
    bit          rdata_rand = 1'b1;
    logic [31:0] rdata_fix  = 32'd0;
    bit          rr_rand    = 1'b0;

    initial begin
        core_halted = 1'b0;
        debug_rdata = 32'd0;
        forever begin
            @(negedge clk);
            case (halt_mode)
                0:       core_halted = 1'b0;
                1:       core_halted = 1'b1;
                default: if ($urandom_range(0, 7) == 0) core_halted = ~core_halted;
            endcase
            debug_rdata = rdata_rand ? $urandom : rdata_fix;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit          wr;
        logic [12:0] idx;
        logic [31:0] wdata;
        int          at;
    } strobe_t;

    logic [31:0] exp_q[$];
    strobe_t     str_q[$];

    bit          m_out, m_active, m_haltreq, m_resumereq, m_resumeack, m_pend, m_pend_wr;
    logic [31:0] m_data0;
    logic [2:0]  m_cmderr;
    int          cyc = 0;
    int          m_start = -10;
    bit          mx_acc, mx_busy, mx_bad;
    logic [31:0] mx_d, mx_rv;
    strobe_t     mx_s;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_out = 0; m_active = 0; m_haltreq = 0; m_resumereq = 0; m_resumeack = 0;
            m_pend = 0; m_pend_wr = 0; m_data0 = 0; m_cmderr = 0;
        end else begin
            cyc++;
            mx_acc = dmi_req_valid && !m_out;
            if (m_out && dmi_resp_ready) m_out = 0;
            mx_busy = m_pend && (cyc > m_start) && (cyc <= m_start + 2);
            if (mx_acc) begin
                mx_rv = 32'd0;
                if (dmi_req_op == 2'd1) begin
                    case (dmi_req_addr)
                        7'h04: mx_rv = m_data0;
                        7'h10: mx_rv = (m_haltreq ? 32'h8000_0000 : 32'd0) | 32'(m_active);
                        7'h11: mx_rv = 32'h82 | (core_halted ? 32'h300 : 32'hC00) |
                                       (m_resumeack ? 32'h3_0000 : 32'd0);
                        7'h16: mx_rv = 32'h1 | (mx_busy ? 32'h1000 : 32'd0) | (32'(m_cmderr) << 8);
                        default: mx_rv = 32'd0;
                    endcase
                end
                exp_q.push_back(mx_rv);
                m_out = 1;
            end
            if (m_pend && cyc == m_start + 2) begin
                if (!m_pend_wr) m_data0 = debug_rdata;
                m_pend = 0;
            end
            if (m_resumereq && !core_halted) begin
                m_resumereq = 0;
                m_resumeack = 1;
            end
            if (mx_acc && dmi_req_op == 2'd2) begin
                mx_d = dmi_req_data;
                if (dmi_req_addr == 7'h10) begin
                    if (!mx_d[0]) begin
                        m_active = 0; m_haltreq = 0; m_resumereq = 0; m_resumeack = 0;
                        m_data0 = 0; m_cmderr = 0; m_pend = 0;
                    end else begin
                        m_active  = 1;
                        m_haltreq = mx_d[31];
                        if (mx_d[30] && !mx_d[31]) begin
                            m_resumereq = 1;
                            m_resumeack = 0;
                        end
                    end
                end else if (m_active) begin
                    case (dmi_req_addr)
                        7'h04: begin
                            if (mx_busy) begin
                                if (m_cmderr == 0) m_cmderr = 1;
                            end else m_data0 = mx_d;
                        end
                        7'h16: m_cmderr = m_cmderr & ~mx_d[10:8];
                        7'h17: begin
                            mx_bad = (mx_d[31:24] != 0) ||
                                     (mx_d[17] && (mx_d[22:20] != 2 || mx_d[15:0] < 16'h1000 ||
                                                   mx_d[15:0] > 16'h101F));
                            if (m_cmderr != 0) ;
                            else if (mx_busy) m_cmderr = 1;
                            else if (mx_bad) m_cmderr = 2;
                            else if (!core_halted) m_cmderr = 4;
                            else if (mx_d[17]) begin
                                m_pend = 1; m_pend_wr = mx_d[16]; m_start = cyc;
                                mx_s.wr = mx_d[16]; mx_s.idx = mx_d[12:0];
                                mx_s.wdata = m_data0; mx_s.at = cyc;
                                str_q.push_back(mx_s);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit          seen = 0;
    int          n_strobes = 0;
    logic [31:0] last_resp = 0;
    logic [4:0]  last_addr = 0;
    logic [31:0] last_wdata = 0;
    logic [31:0] mon_e;
    strobe_t     mon_s;

    initial begin
        dmi_resp_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                seen = 0;
            end else begin
                chk("req_ready", dmi_req_ready, !m_out);
                chk("haltreq", haltreq, m_haltreq);
                chk("resumereq", resumereq, m_resumereq);
                if (debug_read || debug_write) begin
                    n_strobes++;
                    last_addr  = debug_addr;
                    last_wdata = debug_wdata;
                    if (str_q.size() == 0) fail_now("unexpected_strobe");
                    else begin
                        mon_s = str_q.pop_front();
                        chk("strobe_cycle", cyc, mon_s.at);
                        chk("strobe_kind", {debug_write, debug_read}, mon_s.wr ? 2'b10 : 2'b01);
                        chk("register_index", register_index, mon_s.idx);
                        chk("debug_addr", debug_addr, mon_s.idx[4:0]);
                        if (mon_s.wr) chk("debug_wdata", debug_wdata, mon_s.wdata);
                    end
                end else if (str_q.size() > 0 && str_q[0].at < cyc) begin
                    fail_now("missing_strobe");
                    void'(str_q.pop_front());
                end
                if (dmi_resp_valid && !seen) begin
                    seen = 1;
                    last_resp = dmi_resp_data;
                    if (exp_q.size() == 0) fail_now("unexpected_response");
                    else begin
                        mon_e = exp_q.pop_front();
                        chk("dmi_resp", {dmi_resp_resp, dmi_resp_data}, {2'b00, mon_e});
                    end
                end else if (!dmi_resp_valid) begin
                    seen = 0;
                end
            end
            dmi_resp_ready = rr_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic dmi(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
        int t = 0;
        @(negedge clk);
        while (!dmi_req_ready) begin
            @(negedge clk);
            t++;
            if (t > 200) begin
                fail_now("req_ready_timeout");
                return;
            end
        end
        dmi_req_valid = 1'b1;
        dmi_req_op    = op;
        dmi_req_addr  = addr;
        dmi_req_data  = data;
        @(negedge clk);
        dmi_req_valid = 1'b0;
        dmi_req_op    = 2'($urandom);
        dmi_req_addr  = 7'($urandom);
        dmi_req_data  = $urandom;
    endtask

    task automatic wait_resp();
        int t = 0;
        while (m_out) begin
            @(negedge clk);
            t++;
            if (t > 200) begin
                fail_now("resp_timeout");
                return;
            end
        end
    endtask

    task automatic rd_expect(input string name, input logic [6:0] addr, input logic [31:0] exp);
        dmi(2'd1, addr, 32'd0);
        wait_resp();
        chk(name, last_resp, exp);
    endtask

    // ---------------- main sequence ----------------
    int          s0;
    logic [31:0] rd;
    logic [6:0]  ra;
    logic [6:0]  addr_list [5] = '{7'h04, 7'h10, 7'h11, 7'h16, 7'h17};

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", dmi_req_ready, 1);
        chk("rst_resp_valid", dmi_resp_valid, 0);
        chk("rst_haltreq", haltreq, 0);
        chk("rst_strobes", {debug_read, debug_write}, 0);
        chk("rst_register_index", register_index, 0);
        rd_expect("rst_abstractcs", 7'h16, 32'h0000_0001);

        // 1: halt request and dmstatus
        halt_mode = 1;
        idle(2);
        dmi(2'd2, 7'h10, 32'h8000_0001);
        chk("t1_haltreq", haltreq, 1);
        rd_expect("t1_dmstatus", 7'h11, 32'h0000_0382);

        // 2: abstract GPR write
        dmi(2'd2, 7'h04, 32'hDEAD_BEEF);
        s0 = n_strobes;
        dmi(2'd2, 7'h17, 32'h0023_1005);
        rd_expect("t2_busy", 7'h16, 32'h0000_1001);
        rd_expect("t2_done", 7'h16, 32'h0000_0001);
        chk("t2_strobes", n_strobes - s0, 1);
        chk("t2_addr", last_addr, 5);
        chk("t2_wdata", last_wdata, 32'hDEAD_BEEF);

        // 3: abstract GPR read
        rdata_rand = 0;
        rdata_fix  = 32'h1234_5678;
        idle(1);
        dmi(2'd2, 7'h17, 32'h0022_100A);
        idle(4);
        rd_expect("t3_data0", 7'h04, 32'h1234_5678);
        chk("t3_addr", last_addr, 10);
        rdata_rand = 1;

        // 4: command while busy
        s0 = n_strobes;
        dmi(2'd2, 7'h17, 32'h0023_1005);
        dmi(2'd2, 7'h17, 32'h0023_1006);
        dmi(2'd2, 7'h17, 32'h0023_1007);
        idle(4);
        chk("t4_strobes", n_strobes - s0, 1);
        rd_expect("t4_cmderr1", 7'h16, 32'h0000_0101);
        dmi(2'd2, 7'h16, 32'h0000_0700);
        rd_expect("t4_cleared", 7'h16, 32'h0000_0001);

        // 5: error codes
        halt_mode = 0;
        idle(2);
        s0 = n_strobes;
        dmi(2'd2, 7'h17, 32'h0022_1001);
        rd_expect("t5_not_halted", 7'h16, 32'h0000_0401);
        dmi(2'd2, 7'h16, 32'h0000_0700);
        dmi(2'd2, 7'h17, 32'h0022_2000);
        rd_expect("t5_bad_regno", 7'h16, 32'h0000_0201);
        dmi(2'd2, 7'h16, 32'h0000_0700);
        dmi(2'd2, 7'h17, 32'h0032_1001);
        rd_expect("t5_bad_size", 7'h16, 32'h0000_0201);
        dmi(2'd2, 7'h16, 32'h0000_0700);
        idle(3);
        chk("t5_strobes", n_strobes - s0, 0);

        // 6: resume handshake, then deactivate
        halt_mode = 1;
        idle(2);
        dmi(2'd2, 7'h04, 32'h0000_0055);
        dmi(2'd2, 7'h10, 32'h4000_0001);
        idle(1);
        chk("t6_resumereq_set", resumereq, 1);
        halt_mode = 0;
        idle(3);
        chk("t6_resumereq_clr", resumereq, 0);
        rd_expect("t6_dmstatus", 7'h11, 32'h0003_0C82);
        dmi(2'd2, 7'h17, 32'h0022_1001);
        dmi(2'd2, 7'h10, 32'h0000_0000);
        rd_expect("t6_data0_clr", 7'h04, 32'h0000_0000);
        rd_expect("t6_abstractcs_clr", 7'h16, 32'h0000_0001);
        rd_expect("t6_dmstatus_clr", 7'h11, 32'h0000_0C82);
        dmi(2'd2, 7'h10, 32'h0000_0001);

        // random phase
        rr_rand   = 1;
        halt_mode = 2;
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 5) == 0) ? 7'($urandom) : addr_list[$urandom_range(0, 4)];
            case ($urandom_range(0, 9))
                0: dmi(($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3, ra, $urandom);
                1, 2, 3: dmi(2'd1, ra, $urandom);
                default: begin
                    rd = $urandom;
                    if (ra == 7'h17) begin
                        rd[31:24] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
                        rd[22:20] = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd2;
                        rd[17]    = ($urandom_range(0, 5) != 0);
                        rd[16]    = 1'($urandom);
                        rd[15:0]  = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                                 : 16'h1000 + 16'($urandom_range(0, 31));
                    end else if (ra == 7'h16) begin
                        if ($urandom_range(0, 4) != 0) rd = 32'h0000_0700;
                    end else if (ra == 7'h10) begin
                        rd[0] = ($urandom_range(0, 15) != 0);
                    end
                    dmi(2'd2, ra, rd);
                end
            endcase
            idle($urandom_range(0, 3));
        end

        rr_rand = 0;
        idle(20);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("strobes_drained", str_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
